// File: rtl/ir_promediador.sv
// ir_promediador: windowed average of IR discharge samples with hysteresis
// obstacle detection, stalled-sensor watchdog and a sticky new-data flag.
module ir_promediador #(
  parameter int unsigned LOG2_N     = 3,
  parameter logic [7:0]  UMBRAL_ON  = 8'd40,
  parameter logic [7:0]  UMBRAL_OFF = 8'd30,
  parameter logic [15:0] TIMEOUT    = 16'd40000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       descarga,
  input  logic [7:0] distancia,
  input  logic       rd_ack,
  output logic [7:0] distancia_prom,
  output logic       valido,
  output logic       obstaculo,
  output logic       dato_nuevo,
  output logic       falla
);

  localparam int unsigned N  = 1 << LOG2_N;
  localparam int unsigned SW = 8 + LOG2_N;
  localparam logic [LOG2_N:0] N_CNT = (LOG2_N + 1)'(N);

  typedef enum logic [1:0] {LLENANDO, ACTIVO, FALLA} estado_t;

  estado_t           estado;
  logic [7:0]        muestras [N];
  logic [LOG2_N-1:0] ptr;
  logic [SW-1:0]     suma;
  logic [LOG2_N:0]   cuenta;
  logic [15:0]       wd;
  logic              descarga_q;
  logic              calc;
  logic              strobe;
  logic [7:0]        avg;

  // Rising edge of the discharge pulse and the truncated window average
  always_comb begin
    strobe = descarga & ~descarga_q;
    avg    = suma[SW-1:LOG2_N];
  end

  // Circular sample buffer, running sum, write pointer and fill counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) muestras[i] <= '0;
      suma   <= '0;
      ptr    <= '0;
      cuenta <= '0;
    end else if (strobe) begin
      if (estado == FALLA) begin
        // Restart the window with this sample as the first one
        for (int unsigned i = 0; i < N; i++) muestras[i] <= '0;
        muestras[0] <= distancia;
        suma        <= SW'(distancia);
        ptr         <= LOG2_N'(1);
        cuenta      <= (LOG2_N + 1)'(1);
      end else begin
        muestras[ptr] <= distancia;
        suma          <= suma - SW'(muestras[ptr]) + SW'(distancia);
        ptr           <= ptr + 1'b1;
        if (cuenta != N_CNT) cuenta <= cuenta + 1'b1;
      end
    end
  end

  // State machine, watchdog and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado         <= LLENANDO;
      wd             <= '0;
      descarga_q     <= 1'b0;
      calc           <= 1'b0;
      distancia_prom <= '0;
      valido         <= 1'b0;
      obstaculo      <= 1'b0;
      dato_nuevo     <= 1'b0;
      falla          <= 1'b0;
    end else begin
      descarga_q <= descarga;
      calc       <= 1'b0;
      valido     <= calc;

      if (strobe) wd <= '0;
      else if (wd != '1) wd <= wd + 1'b1;

      if (calc) begin
        distancia_prom <= avg;
        if (avg >= UMBRAL_ON) obstaculo <= 1'b1;
        else if (avg < UMBRAL_OFF) obstaculo <= 1'b0;
      end

      // An ack seen while valido is high refers to the previous result, so it
      // must not clear the flag that result has just set.
      if (calc) dato_nuevo <= 1'b1;
      else if (rd_ack && !valido) dato_nuevo <= 1'b0;

      case (estado)
        LLENANDO: begin
          if (strobe) begin
            if (cuenta == N_CNT - 1'b1) begin
              estado <= ACTIVO;
              calc   <= 1'b1;
            end
          end else if (wd >= TIMEOUT) begin
            estado    <= FALLA;
            falla     <= 1'b1;
            obstaculo <= 1'b1;
          end
        end
        ACTIVO: begin
          if (strobe) begin
            calc <= 1'b1;
          end else if (wd >= TIMEOUT) begin
            estado    <= FALLA;
            falla     <= 1'b1;
            obstaculo <= 1'b1;
          end
        end
        FALLA: begin
          obstaculo <= 1'b1;
          if (strobe) begin
            estado <= LLENANDO;
            falla  <= 1'b0;
          end
        end
        default: estado <= LLENANDO;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_promediador.sv
// Testbench for ir_promediador: table of strobes with hand-derived averages,
// scoreboard queue of expected results, plus reset/handshake/timeout sequences.
module tb_ir_promediador;

  logic       clk;
  logic       rst;
  logic       descarga;
  logic [7:0] distancia;
  logic       rd_ack;
  logic [7:0] distancia_prom;
  logic       valido;
  logic       obstaculo;
  logic       dato_nuevo;
  logic       falla;

  ir_promediador #(
    .LOG2_N    (3),
    .UMBRAL_ON (8'd40),
    .UMBRAL_OFF(8'd30),
    .TIMEOUT   (16'd40000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .descarga      (descarga),
    .distancia     (distancia),
    .rd_ack        (rd_ack),
    .distancia_prom(distancia_prom),
    .valido        (valido),
    .obstaculo     (obstaculo),
    .dato_nuevo    (dato_nuevo),
    .falla         (falla)
  );

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic [7:0] prom;
    logic       obst;
  } vec_t;

  vec_t       tabla[$];
  logic [8:0] exp_q[$];
  int         tests = 0;
  int         fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Eight strobes of value d; proms packed first-strobe-in-MSB, obst/vmask bit 7 = first
  task automatic add8(input logic [7:0] d, input logic [63:0] proms,
                      input logic [7:0] obst, input logic [7:0] vmask);
    for (int i = 0; i < 8; i++) begin
      vec_t e;
      e.d    = d;
      e.v    = vmask[7-i];
      e.prom = proms[63-8*i -: 8];
      e.obst = obst[7-i];
      tabla.push_back(e);
    end
  endtask

  // One front-end sample: data one cycle ahead of the rising strobe
  task automatic strobe(input logic [7:0] d, input logic ev, input logic [7:0] p, input logic o);
    @(negedge clk) distancia = d;
    if (ev) exp_q.push_back({p, o});
    @(negedge clk) descarga = 1'b1;
    @(negedge clk) descarga = 1'b0;
    @(negedge clk) chk("valido_latency", 16'(valido), 16'(ev));
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard consumer: every valido pulse pops one expected result
  initial begin
    forever begin
      @(negedge clk);
      if (valido === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valido: got prom %0d with no result expected", distancia_prom);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("prom", 16'(distancia_prom), 16'(e[8:1]));
          chk("obstaculo", 16'(obstaculo), 16'(e[0]));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; descarga = 1'b0; distancia = '0; rd_ack = 1'b0;

    add8(8'd50,  {56'd0, 8'd50},                                    8'b00000001, 8'b00000001);
    add8(8'd255, {8'd75, 8'd101, 8'd126, 8'd152, 8'd178, 8'd203, 8'd229, 8'd255}, 8'hFF, 8'hFF);
    add8(8'd0,   {8'd223, 8'd191, 8'd159, 8'd127, 8'd95, 8'd63, 8'd31, 8'd0},     8'b11111110, 8'hFF);
    add8(8'd50,  {8'd6, 8'd12, 8'd18, 8'd25, 8'd31, 8'd37, 8'd43, 8'd50},         8'b00000011, 8'hFF);
    add8(8'd35,  {8'd48, 8'd46, 8'd44, 8'd42, 8'd40, 8'd38, 8'd36, 8'd35},        8'hFF, 8'hFF);
    add8(8'd20,  {8'd33, 8'd31, 8'd29, 8'd27, 8'd25, 8'd23, 8'd21, 8'd20},        8'b11000000, 8'hFF);
    add8(8'd35,  {8'd21, 8'd23, 8'd25, 8'd27, 8'd29, 8'd31, 8'd33, 8'd35},        8'h00, 8'hFF);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_prom", 16'(distancia_prom), 16'd0);
    chk("rst_valido", 16'(valido), 16'd0);
    chk("rst_obst", 16'(obstaculo), 16'd0);
    chk("rst_dato", 16'(dato_nuevo), 16'd0);
    chk("rst_falla", 16'(falla), 16'd0);
    @(negedge clk) rst = 1'b1;

    // Fill, full-scale window, wrap-down and hysteresis
    foreach (tabla[i]) strobe(tabla[i].d, tabla[i].v, tabla[i].prom, tabla[i].obst);
    chk("queue_drained_table", 16'(exp_q.size()), 16'd0);
    chk("dato_after_fill", 16'(dato_nuevo), 16'd1);

    // Handshake: plain ack clears the flag
    @(negedge clk) rd_ack = 1'b1;
    @(negedge clk) rd_ack = 1'b0;
    chk("dato_ack_clear", 16'(dato_nuevo), 16'd0);

    // Ack during the valido cycle keeps the new flag set
    exp_q.push_back({8'd35, 1'b0});
    @(negedge clk) distancia = 8'd35;
    @(negedge clk) descarga = 1'b1;
    @(negedge clk) descarga = 1'b0;
    @(negedge clk);
    chk("valido_before_ack", 16'(valido), 16'd1);
    rd_ack = 1'b1;
    @(negedge clk) rd_ack = 1'b0;
    chk("dato_ack_in_valido", 16'(dato_nuevo), 16'd1);
    repeat (2) @(negedge clk);

    // Mid-run asynchronous reset with non-zero outputs
    strobe(8'd255, 1'b1, 8'd62, 1'b1);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_prom", 16'(distancia_prom), 16'd0);
    chk("mid_rst_obst", 16'(obstaculo), 16'd0);
    chk("mid_rst_dato", 16'(dato_nuevo), 16'd0);
    chk("mid_rst_valido", 16'(valido), 16'd0);
    chk("mid_rst_falla", 16'(falla), 16'd0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 7; i++) strobe(8'd10, 1'b0, 8'd0, 1'b0);
    strobe(8'd10, 1'b1, 8'd10, 1'b0);

    // Watchdog
    repeat (39990) @(negedge clk);
    chk("falla_not_yet", 16'(falla), 16'd0);
    repeat (20) @(negedge clk);
    chk("falla_set", 16'(falla), 16'd1);
    chk("falla_obst_forced", 16'(obstaculo), 16'd1);

    // Recovery: first strobe restarts filling, seven more yield a result
    strobe(8'd200, 1'b0, 8'd0, 1'b0);
    chk("falla_cleared", 16'(falla), 16'd0);
    for (int i = 0; i < 6; i++) strobe(8'd200, 1'b0, 8'd0, 1'b0);
    strobe(8'd200, 1'b1, 8'd200, 1'b1);

    chk("queue_drained_end", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
